// File: rtl/mlp_mac_pipe.sv
// Pipelined signed multiply-accumulate for MLP dot products: full-precision accumulation
// over first/last framed vectors, then round-half-up, saturate and optional ReLU per vector.
module mlp_mac_pipe #(
    parameter int DIN0_W    = 16,
    parameter int DIN1_W    = 16,
    parameter int ACC_W     = 40,
    parameter int DOUT_W    = 16,
    parameter int FRAC_BITS = 10,
    parameter int MUL_STAGE = 2,
    parameter int RELU_EN   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic signed [DIN0_W-1:0] din0,
    input  logic signed [DIN1_W-1:0] din1,
    output logic                     out_valid,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     out_sat
);

    localparam int PROD_W = DIN0_W + DIN1_W;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-DOUT_W){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-DOUT_W){1'b1}}, {(DOUT_W-1){1'b0}}};

    logic                     r_v, r_f, r_l;
    logic signed [DIN0_W-1:0] r_din0;
    logic signed [DIN1_W-1:0] r_din1;

    logic signed [PROD_W-1:0] r_prod [MUL_STAGE];
    logic [MUL_STAGE-1:0]     r_pv, r_pf, r_pl;

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_res;
    logic                     r_res_valid;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_p_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W:0]    w_r;
    logic signed [DOUT_W-1:0] w_clip;
    logic                     w_clip_sat;
    logic signed [DOUT_W-1:0] w_dout;
    logic                     w_out_sat;

    assign w_prod  = PROD_W'(r_din0) * PROD_W'(r_din1);
    assign w_p_ext = ACC_W'(r_prod[MUL_STAGE-1]);
    // A first beat discards whatever partial sum is in the accumulator.
    assign w_sum   = r_pf[MUL_STAGE-1] ? w_p_ext : r_acc + w_p_ext;

    generate
        if (FRAC_BITS > 0) begin : g_round
            localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (FRAC_BITS-1);
            logic signed [ACC_W:0] w_rnd;
            // One extra bit so adding the half-LSB can never wrap.
            assign w_rnd = (ACC_W+1)'(r_res) + RND_HALF;
            assign w_r   = w_rnd >>> FRAC_BITS;
        end else begin : g_noround
            assign w_r = (ACC_W+1)'(r_res);
        end
    endgenerate

    always_comb begin
        w_clip     = w_r[DOUT_W-1:0];
        w_clip_sat = 1'b0;
        if (w_r > SAT_MAX) begin
            w_clip     = {1'b0, {(DOUT_W-1){1'b1}}};
            w_clip_sat = 1'b1;
        end else if (w_r < SAT_MIN) begin
            w_clip     = {1'b1, {(DOUT_W-1){1'b0}}};
            w_clip_sat = 1'b1;
        end
        w_dout    = w_clip;
        w_out_sat = w_clip_sat;
        // ReLU clamping overrides saturation: a clamped result is not flagged as clipped.
        if (RELU_EN != 0 && w_clip[DOUT_W-1]) begin
            w_dout    = '0;
            w_out_sat = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v         <= 1'b0;
            r_f         <= 1'b0;
            r_l         <= 1'b0;
            r_din0      <= '0;
            r_din1      <= '0;
            r_pv        <= '0;
            r_pf        <= '0;
            r_pl        <= '0;
            for (int i = 0; i < MUL_STAGE; i++) r_prod[i] <= '0;
            r_acc       <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            out_valid   <= 1'b0;
            dout        <= '0;
            out_sat     <= 1'b0;
        end else if (ce) begin
            r_v    <= in_valid;
            r_f    <= in_first;
            r_l    <= in_last;
            r_din0 <= din0;
            r_din1 <= din1;

            r_prod[0] <= w_prod;
            r_pv[0]   <= r_v;
            r_pf[0]   <= r_f;
            r_pl[0]   <= r_l;
            for (int i = 1; i < MUL_STAGE; i++) begin
                r_prod[i] <= r_prod[i-1];
                r_pv[i]   <= r_pv[i-1];
                r_pf[i]   <= r_pf[i-1];
                r_pl[i]   <= r_pl[i-1];
            end

            r_res_valid <= 1'b0;
            if (r_pv[MUL_STAGE-1]) begin
                if (r_pl[MUL_STAGE-1]) begin
                    r_res       <= w_sum;
                    r_res_valid <= 1'b1;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_sum;
                end
            end

            out_valid <= r_res_valid;
            if (r_res_valid) begin
                dout    <= w_dout;
                out_sat <= w_out_sat;
            end
        end
    end

endmodule
